// File: rtl/pwm_duty_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Purpose:
//   Owns one PWM channel. A free-running period counter is compared with a
//   threshold derived from the duty code currently in effect, and the result
//   drives a registered PWM pin. Duty change requests arrive over a
//   valid/ready handshake. Each request is applied either as a single jump or
//   as a +/-1 code-per-step ramp. Duty changes only ever land in the wrap
//   cycle, so every period on the pin is whole (no runt or stretched pulses).
//
// Parameters:
//   CBITS         period counter width, period = 2**CBITS clocks
//   DBITS         duty code width (CBITS >= DBITS+3)
//   STEP_PERIODS  PWM periods per ramp step (>= 1)
//
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     duty request valid
//   req_ready     high while idle; transfer = req_valid & req_ready
//   req_duty      target duty code (sampled on transfer only)
//   req_ramp      1 = ramp to target, 0 = jump at next period boundary
//   pwm_out       registered PWM output
//   cur_duty      duty code currently in effect
//   busy          a request is in progress
//   period_start  registered one-cycle pulse, high while the counter is 0
// -----------------------------------------------------------------------------
module pwm_duty_sequencer #(
  parameter int CBITS        = 15,
  parameter int DBITS        = 4,
  parameter int STEP_PERIODS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DBITS-1:0] req_duty,
  input  logic             req_ramp,
  output logic             pwm_out,
  output logic [DBITS-1:0] cur_duty,
  output logic             busy,
  output logic             period_start
);

  // A single-period ramp still needs a one-bit step counter so the
  // comparison logic below stays uniform.
  localparam int SBITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SBITS-1:0] STEP_LAST = SBITS'(STEP_PERIODS - 1);
  localparam logic [DBITS-1:0] DUTY_MAX  = '1;
  localparam logic [DBITS-1:0] DUTY_MIN  = '0;

  typedef enum logic [1:0] {
    IDLE,
    JUMP,
    RAMP
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CBITS-1:0]   r_cnt;
  logic               r_pwm;
  logic               r_periodStart;
  logic [DBITS-1:0]   r_curDuty;
  logic [DBITS-1:0]   w_curDutyNext;
  logic [DBITS-1:0]   r_target;
  logic [DBITS-1:0]   w_targetNext;
  logic [SBITS-1:0]   r_stepCnt;
  logic [SBITS-1:0]   w_stepCntNext;
  logic               w_wrap;
  logic               w_transfer;
  logic [CBITS-1:0]   w_thr;
  logic [DBITS-1:0]   w_stepDuty;

  assign w_wrap     = (r_cnt == {CBITS{1'b1}});
  assign req_ready  = (r_state == IDLE);
  assign busy       = ~req_ready;
  assign w_transfer = req_valid & req_ready;

  // Threshold = (2*code + 1) * 2**(CBITS-DBITS-2): code 0 still gives a
  // short pulse and the top code stays below half of the period.
  assign w_thr = {1'b0, r_curDuty, 1'b1, {(CBITS-DBITS-2){1'b0}}};

  // One ramp step toward the target; never moves past it and never wraps
  // the code at either end.
  always_comb begin
    w_stepDuty = r_curDuty;
    if ((r_target > r_curDuty) && (r_curDuty != DUTY_MAX)) begin
      w_stepDuty = r_curDuty + 1'b1;
    end else if ((r_target < r_curDuty) && (r_curDuty != DUTY_MIN)) begin
      w_stepDuty = r_curDuty - 1'b1;
    end
  end

  // FSM next-state and datapath next values. The duty code only changes in
  // the wrap cycle, so the new threshold governs from cnt == 0. A transfer
  // that coincides with a wrap is seen while still in IDLE, so its first
  // application is naturally deferred to the following wrap.
  always_comb begin
    w_stateNext   = r_state;
    w_curDutyNext = r_curDuty;
    w_targetNext  = r_target;
    w_stepCntNext = r_stepCnt;
    case (r_state)
      IDLE: begin
        if (w_transfer) begin
          w_targetNext = req_duty;
          if (req_duty == r_curDuty) begin
            w_stateNext = IDLE;
          end else if (!req_ramp) begin
            w_stateNext = JUMP;
          end else begin
            w_stateNext   = RAMP;
            w_stepCntNext = '0;
          end
        end
      end
      JUMP: begin
        if (w_wrap) begin
          w_curDutyNext = r_target;
          w_stateNext   = IDLE;
        end
      end
      RAMP: begin
        if (w_wrap) begin
          if (r_stepCnt != STEP_LAST) begin
            w_stepCntNext = r_stepCnt + 1'b1;
          end else begin
            w_stepCntNext = '0;
            w_curDutyNext = w_stepDuty;
            if (w_stepDuty == r_target) begin
              w_stateNext = IDLE;
            end
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Counter, duty datapath and registered pin outputs. period_start is
  // registered from the wrap condition so that it is high while cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_pwm         <= 1'b0;
      r_periodStart <= 1'b0;
      r_curDuty     <= '0;
      r_target      <= '0;
      r_stepCnt     <= '0;
    end else begin
      r_cnt         <= r_cnt + 1'b1;
      r_pwm         <= (r_cnt < w_thr);
      r_periodStart <= w_wrap;
      r_curDuty     <= w_curDutyNext;
      r_target      <= w_targetNext;
      r_stepCnt     <= w_stepCntNext;
    end
  end

  assign pwm_out      = r_pwm;
  assign cur_duty     = r_curDuty;
  assign period_start = r_periodStart;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pwm_duty_sequencer
//
// Purpose:
//   Directed self-checking bench for pwm_duty_sequencer with CBITS=8, DBITS=4
//   (period 256 clocks, high time = 8*code + 4). Two instances share clock
//   and reset: dutA with STEP_PERIODS=1 and dutB with STEP_PERIODS=2.
//   A bench-side counter follows the period position so stimulus can be
//   placed at exact counter values.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       reqValidA = 1'b0;
  logic       reqReadyA;
  logic [3:0] reqDutyA = 4'd0;
  logic       reqRampA = 1'b0;
  logic       pwmOutA;
  logic [3:0] curDutyA;
  logic       busyA;
  logic       periodStartA;

  logic       reqValidB = 1'b0;
  logic       reqReadyB;
  logic [3:0] reqDutyB = 4'd0;
  logic       reqRampB = 1'b0;
  logic       pwmOutB;
  logic [3:0] curDutyB;
  logic       busyB;
  logic       periodStartB;

  logic [7:0] tbCnt;
  int         errors = 0;
  int         checks = 0;

  pwm_duty_sequencer #(.CBITS(8), .DBITS(4), .STEP_PERIODS(1)) dutA (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (reqValidA),
    .req_ready    (reqReadyA),
    .req_duty     (reqDutyA),
    .req_ramp     (reqRampA),
    .pwm_out      (pwmOutA),
    .cur_duty     (curDutyA),
    .busy         (busyA),
    .period_start (periodStartA)
  );

  pwm_duty_sequencer #(.CBITS(8), .DBITS(4), .STEP_PERIODS(2)) dutB (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (reqValidB),
    .req_ready    (reqReadyB),
    .req_duty     (reqDutyB),
    .req_ramp     (reqRampB),
    .pwm_out      (pwmOutB),
    .cur_duty     (curDutyB),
    .busy         (busyB),
    .period_start (periodStartB)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Bench copy of the period position, cleared by the same reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbCnt <= 8'd0;
    else        tbCnt <= tbCnt + 8'd1;
  end

  // Runaway guard.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int thrOf(input int code);
    return code * 8 + 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance at least one cycle, until the period position equals v.
  task automatic waitCnt(input logic [7:0] v);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((tbCnt != v) && (n < 300));
  endtask

  // Called at cnt == 0; samples one whole period and returns to cnt == 0.
  task automatic measurePeriod(output int highA, output int highB, output int startsA);
    highA = 0;
    highB = 0;
    startsA = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwmOutA) highA++;
      if (pwmOutB) highB++;
      if (periodStartA) startsA++;
      tick();
    end
  endtask

  task automatic test_reset();
    int hA, hB, sA;
    tick(); tick(); tick();
    rst_n = 1'b1;
    waitCnt(8'd2);
    checks++;
    if (pwmOutA !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_pwm: got %0b expected 1", pwmOutA); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwmOutA !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm: got %0b expected 0", pwmOutA); end
    checks++;
    if (curDutyA !== 4'd0) begin errors++; $display("[TB] FAIL reset_duty: got %0d expected 0", curDutyA); end
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", reqReadyA); end
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busyA); end
    checks++;
    if (periodStartA !== 1'b0) begin errors++; $display("[TB] FAIL reset_pstart: got %0b expected 0", periodStartA); end
    tick(); tick();
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_hold_ready: got %0b expected 1", reqReadyA); end
    rst_n = 1'b1;
    waitCnt(8'd0);
    for (int p = 0; p < 2; p++) begin
      measurePeriod(hA, hB, sA);
      checks++;
      if (hA !== thrOf(0)) begin errors++; $display("[TB] FAIL reset_high_A: got %0d expected %0d", hA, thrOf(0)); end
      checks++;
      if (hB !== thrOf(0)) begin errors++; $display("[TB] FAIL reset_high_B: got %0d expected %0d", hB, thrOf(0)); end
      checks++;
      if (sA !== 1) begin errors++; $display("[TB] FAIL reset_pstart_count: got %0d expected 1", sA); end
    end
  endtask

  task automatic test_jump();
    int hA, hB, sA;
    waitCnt(8'd100);
    reqDutyA = 4'd15; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    checks++;
    if (reqReadyA !== 1'b0) begin errors++; $display("[TB] FAIL jump_ready_drop: got %0b expected 0", reqReadyA); end
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL jump_busy: got %0b expected 1", busyA); end
    waitCnt(8'd255);
    checks++;
    if (curDutyA !== 4'd0) begin errors++; $display("[TB] FAIL jump_duty_before_wrap: got %0d expected 0", curDutyA); end
    tick();
    checks++;
    if (curDutyA !== 4'd15) begin errors++; $display("[TB] FAIL jump_duty_after_wrap: got %0d expected 15", curDutyA); end
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL jump_ready_back: got %0b expected 1", reqReadyA); end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(15)) begin errors++; $display("[TB] FAIL jump_high: got %0d expected %0d", hA, thrOf(15)); end
  endtask

  task automatic test_ramp_up();
    int hA, hB, sA;
    int expDuty [6] = '{0, 1, 1, 2, 2, 3};
    waitCnt(8'd10);
    reqDutyB = 4'd3; reqRampB = 1'b1; reqValidB = 1'b1;
    tick();
    reqValidB = 1'b0;
    checks++;
    if (busyB !== 1'b1) begin errors++; $display("[TB] FAIL rampup_busy_start: got %0b expected 1", busyB); end
    waitCnt(8'd0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (curDutyB !== 4'(expDuty[k])) begin
        errors++; $display("[TB] FAIL rampup_duty_p%0d: got %0d expected %0d", k, curDutyB, expDuty[k]);
      end
      checks++;
      if (busyB !== (k < 5)) begin
        errors++; $display("[TB] FAIL rampup_busy_p%0d: got %0b expected %0b", k, busyB, (k < 5));
      end
      measurePeriod(hA, hB, sA);
      checks++;
      if (hB !== thrOf(expDuty[k])) begin
        errors++; $display("[TB] FAIL rampup_high_p%0d: got %0d expected %0d", k, hB, thrOf(expDuty[k]));
      end
    end
  endtask

  task automatic test_ramp_down();
    int hA, hB, sA;
    int expDuty [3] = '{4, 3, 2};
    waitCnt(8'd10);
    reqDutyA = 4'd5; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    waitCnt(8'd0);
    checks++;
    if (curDutyA !== 4'd5) begin errors++; $display("[TB] FAIL rampdn_preset: got %0d expected 5", curDutyA); end
    waitCnt(8'd10);
    reqDutyA = 4'd2; reqRampA = 1'b1; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waitCnt(8'd0);
      checks++;
      if (curDutyA !== 4'(expDuty[k])) begin
        errors++; $display("[TB] FAIL rampdn_duty_w%0d: got %0d expected %0d", k, curDutyA, expDuty[k]);
      end
      checks++;
      if (busyA !== (k < 2)) begin
        errors++; $display("[TB] FAIL rampdn_busy_w%0d: got %0b expected %0b", k, busyA, (k < 2));
      end
    end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(2)) begin errors++; $display("[TB] FAIL rampdn_high: got %0d expected %0d", hA, thrOf(2)); end
  endtask

  task automatic test_same_duty();
    int hA, hB, sA;
    int sawBusy = 0;
    waitCnt(8'd10);
    reqDutyA = 4'd2; reqRampA = 1'b1; reqValidA = 1'b1;
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL same_accept: got %0b expected 1", reqReadyA); end
    tick();
    reqValidA = 1'b0;
    do begin
      if (busyA) sawBusy++;
      tick();
    end while (tbCnt != 8'd0);
    checks++;
    if (sawBusy !== 0) begin errors++; $display("[TB] FAIL same_busy_cycles: got %0d expected 0", sawBusy); end
    checks++;
    if (curDutyA !== 4'd2) begin errors++; $display("[TB] FAIL same_duty: got %0d expected 2", curDutyA); end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(2)) begin errors++; $display("[TB] FAIL same_high: got %0d expected %0d", hA, thrOf(2)); end
  endtask

  task automatic test_wrap_request();
    int hA, hB, sA;
    waitCnt(8'd255);
    reqDutyA = 4'd7; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    checks++;
    if (curDutyA !== 4'd2) begin errors++; $display("[TB] FAIL wrapreq_duty_now: got %0d expected 2", curDutyA); end
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL wrapreq_busy: got %0b expected 1", busyA); end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(2)) begin errors++; $display("[TB] FAIL wrapreq_old_high: got %0d expected %0d", hA, thrOf(2)); end
    checks++;
    if (curDutyA !== 4'd7) begin errors++; $display("[TB] FAIL wrapreq_duty_later: got %0d expected 7", curDutyA); end
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL wrapreq_idle: got %0b expected 0", busyA); end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(7)) begin errors++; $display("[TB] FAIL wrapreq_new_high: got %0d expected %0d", hA, thrOf(7)); end
  endtask

  task automatic test_back_to_back();
    waitCnt(8'd10);
    reqDutyA = 4'd9; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqDutyA = 4'd12;
    checks++;
    if (reqReadyA !== 1'b0) begin errors++; $display("[TB] FAIL held_ready_busy: got %0b expected 0", reqReadyA); end
    waitCnt(8'd200);
    checks++;
    if (reqReadyA !== 1'b0) begin errors++; $display("[TB] FAIL held_ready_mid: got %0b expected 0", reqReadyA); end
    checks++;
    if (curDutyA !== 4'd7) begin errors++; $display("[TB] FAIL held_duty_mid: got %0d expected 7", curDutyA); end
    waitCnt(8'd0);
    checks++;
    if (curDutyA !== 4'd9) begin errors++; $display("[TB] FAIL held_first_target: got %0d expected 9", curDutyA); end
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL held_ready_idle: got %0b expected 1", reqReadyA); end
    tick();
    reqValidA = 1'b0;
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL held_second_accept: got %0b expected 1", busyA); end
    waitCnt(8'd0);
    checks++;
    if (curDutyA !== 4'd12) begin errors++; $display("[TB] FAIL held_second_target: got %0d expected 12", curDutyA); end
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL held_second_idle: got %0b expected 0", busyA); end
  endtask

  task automatic test_reset_mid_ramp();
    int hA, hB, sA;
    waitCnt(8'd10);
    reqDutyA = 4'd0; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    waitCnt(8'd0);
    checks++;
    if (curDutyA !== 4'd0) begin errors++; $display("[TB] FAIL rstramp_preset: got %0d expected 0", curDutyA); end
    waitCnt(8'd10);
    reqDutyA = 4'd15; reqRampA = 1'b1; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    waitCnt(8'd0);
    waitCnt(8'd0);
    waitCnt(8'd0);
    waitCnt(8'd5);
    checks++;
    if (curDutyA !== 4'd3) begin errors++; $display("[TB] FAIL rstramp_three_steps: got %0d expected 3", curDutyA); end
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL rstramp_busy: got %0b expected 1", busyA); end
    checks++;
    if (pwmOutA !== 1'b1) begin errors++; $display("[TB] FAIL rstramp_pwm_pre: got %0b expected 1", pwmOutA); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (curDutyA !== 4'd0) begin errors++; $display("[TB] FAIL rstramp_duty: got %0d expected 0", curDutyA); end
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL rstramp_idle: got %0b expected 0", busyA); end
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL rstramp_ready: got %0b expected 1", reqReadyA); end
    checks++;
    if (pwmOutA !== 1'b0) begin errors++; $display("[TB] FAIL rstramp_pwm: got %0b expected 0", pwmOutA); end
    checks++;
    if (curDutyB !== 4'd0) begin errors++; $display("[TB] FAIL rstramp_duty_B: got %0d expected 0", curDutyB); end
    tick(); tick();
    rst_n = 1'b1;
    waitCnt(8'd10);
    reqDutyA = 4'd6; reqRampA = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL postrst_busy: got %0b expected 1", busyA); end
    waitCnt(8'd0);
    checks++;
    if (curDutyA !== 4'd6) begin errors++; $display("[TB] FAIL postrst_duty: got %0d expected 6", curDutyA); end
    checks++;
    if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL postrst_ready: got %0b expected 1", reqReadyA); end
    measurePeriod(hA, hB, sA);
    checks++;
    if (hA !== thrOf(6)) begin errors++; $display("[TB] FAIL postrst_high: got %0d expected %0d", hA, thrOf(6)); end
  endtask

  initial begin
    $display("[TB] starting pwm_duty_sequencer directed tests");
    test_reset();
    test_jump();
    test_ramp_up();
    test_ramp_down();
    test_same_duty();
    test_wrap_request();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
